mips_ifetch_bridge: RTL and testbench
=====================================

MIPS_IFETCH_BRIDGE -- requirements
Module: mips_ifetch_bridge

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, giving max wait cycles for mem_ack_i before abort (range 1..255).
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have port pc_i, input, 32, fetch address from core (zz_pc_o).
REQ-005 SHALL have port flush_i, input, 1, invalidates the fetch buffer (branch/irq redirect).
REQ-006 SHALL have port ins_o, output, 32, instruction to core (zz_ins_i).
REQ-007 SHALL have port pause_o, output, 1, stalls core while instruction not available.
REQ-008 SHALL have port mem_req_o, output, 1, memory read request.
REQ-009 SHALL have port mem_addr_o, output, 32, word-aligned memory read address.
REQ-010 SHALL have port mem_rdata_i, input, 32, memory read data, valid with mem_ack_i.
REQ-011 SHALL have port mem_ack_i, input, 1, one-cycle read completion.
REQ-012 SHALL have port err_o, output, 1, one-cycle pulse on fetch error.

Function
REQ-013 SHALL hold a single-entry buffer: buf_valid, buf_tag[29:0], buf_data[31:0].
REQ-014 SHALL define hit = buf_valid and buf_tag == pc_i[31:2], combinational.
REQ-015 SHALL implement FSM states IDLE and WAIT.
REQ-016 In IDLE with hit: ins_o = buf_data, pause_o = 0, same cycle (combinational).
REQ-017 In IDLE with miss and pc_i[1:0]==0: ins_o = 0 (NOP), pause_o = 1; next edge -> WAIT, mem_req_o = 1, mem_addr_o = {pc_i[31:2],2'b00}, timeout counter = 0, stale = 0.
REQ-018 In IDLE with pc_i[1:0]!=0 and no hit: ins_o = 0, pause_o = 0, no request, err_o = 1 next cycle.
REQ-019 In WAIT: pause_o = 1, ins_o = 0; mem_req_o and mem_addr_o held constant until ack or timeout; pc_i changes ignored.
REQ-020 On mem_ack_i in WAIT: if not stale and flush_i = 0, buf_tag <= mem_addr_o[31:2], buf_data <= mem_rdata_i, buf_valid <= 1; always mem_req_o <= 0 and state <= IDLE.
REQ-021 Minimum miss penalty SHALL be 2 cycles: miss at N, req at N+1, ack at N+1, pause_o = 0 at N+2 if pc_i unchanged.
REQ-022 Counter SHALL increment each WAIT cycle without ack; at count == TIMEOUT-1 without ack: mem_req_o <= 0, state <= IDLE, err_o <= 1 for one cycle, buffer unchanged.
REQ-023 Ack and timeout in the same cycle: ack SHALL win, no err_o.
REQ-024 flush_i SHALL clear buf_valid at next edge in any state; in WAIT it SHALL set stale so the pending fill is discarded on ack.
REQ-025 flush_i and mem_ack_i in same cycle: flush wins, buffer invalid.
REQ-026 After returning to IDLE, hit SHALL be re-evaluated against current pc_i; a still-missing pc re-requests.
REQ-027 mem_ack_i outside WAIT SHALL be ignored.

Reset
REQ-028 While rst = 1: state IDLE, buf_valid 0, buf_tag 0, buf_data 0, stale 0, counter 0, mem_req_o 0, mem_addr_o 0, err_o 0, pause_o 1, ins_o 0.
REQ-029 rst asserted in WAIT SHALL abort the request next edge without err_o; a late ack SHALL be ignored.

Verification
REQ-030 Reset release, pc_i=0x00000000, ack one cycle after req with rdata 0x00000000 -> pause_o high 2 cycles then low, ins_o = 0x00000000.
REQ-031 pc_i=0x100, ack after 3 wait cycles with 0x0000000C (SYSCALL) -> mem_addr_o=0x100, pause_o low and ins_o=0x0000000C at ack+1; pc_i=0x104 -> new request, mem_addr_o=0x104.
REQ-032 pc_i=0x200, no ack, TIMEOUT=4 -> mem_req_o drops after 4 WAIT cycles, err_o single pulse, request reissued next cycle.
REQ-033 Miss on 0x300, flush_i pulsed in WAIT, ack with 0x12345678 -> buf_valid 0, pause_o stays 1, new request for current pc_i.
REQ-034 pc_i=0x302 -> no mem_req_o, ins_o = 0, pause_o = 0, err_o pulse next cycle.
REQ-035 Ack and flush_i same cycle; ack and timeout same cycle -> buffer invalid in first case; buffer filled, no err_o in second.

Source files
------------

// File: rtl/mips_ifetch_bridge.sv
// Instruction-fetch bridge between a MIPS core and a simple ack-based memory port.
// Holds a single-entry instruction buffer and stalls the core on a miss until the fill returns.
module mips_ifetch_bridge #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_i,
  input  logic        flush_i,
  output logic [31:0] ins_o,
  output logic        pause_o,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_ack_i,
  output logic        err_o
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic        buf_valid_q, buf_valid_d;
  logic [29:0] buf_tag_q, buf_tag_d;
  logic [31:0] buf_data_q, buf_data_d;
  logic        stale_q, stale_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        mem_req_q, mem_req_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic        err_q, err_d;
  logic        hit_s;
  logic [31:0] ins_s;
  logic        pause_s;

  assign hit_s = buf_valid_q && (buf_tag_q == pc_i[31:2]);

  always_comb begin
    state_d     = state_q;
    buf_valid_d = buf_valid_q;
    buf_tag_d   = buf_tag_q;
    buf_data_d  = buf_data_q;
    stale_d     = stale_q;
    cnt_d       = cnt_q;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    err_d       = 1'b0;
    ins_s       = 32'h0000_0000;
    pause_s     = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (hit_s) begin
          ins_s   = buf_data_q;
          pause_s = 1'b0;
        end else if (pc_i[1:0] != 2'b00) begin
          // Misaligned fetch: let the core run a NOP and report the fault.
          pause_s = 1'b0;
          err_d   = 1'b1;
        end else begin
          state_d    = S_WAIT;
          mem_req_d  = 1'b1;
          mem_addr_d = {pc_i[31:2], 2'b00};
          cnt_d      = 8'd0;
          stale_d    = 1'b0;
        end
      end
      S_WAIT: begin
        if (mem_ack_i) begin
          if (!stale_q && !flush_i) begin
            buf_tag_d   = mem_addr_q[31:2];
            buf_data_d  = mem_rdata_i;
            buf_valid_d = 1'b1;
          end else begin
            buf_valid_d = buf_valid_q;
          end
          mem_req_d = 1'b0;
          state_d   = S_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          mem_req_d = 1'b0;
          state_d   = S_IDLE;
          err_d     = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d   = S_IDLE;
        mem_req_d = 1'b0;
      end
    endcase

    // A flush beats any fill landing in the same cycle and poisons an outstanding one.
    if (flush_i) begin
      buf_valid_d = 1'b0;
      if (state_q == S_WAIT) begin
        stale_d = 1'b1;
      end else begin
        stale_d = stale_d;
      end
    end else begin
      buf_valid_d = buf_valid_d;
    end
  end

  always_comb begin
    if (rst) begin
      ins_o   = 32'h0000_0000;
      pause_o = 1'b1;
    end else begin
      ins_o   = ins_s;
      pause_o = pause_s;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      buf_valid_q <= 1'b0;
      buf_tag_q   <= 30'd0;
      buf_data_q  <= 32'h0000_0000;
      stale_q     <= 1'b0;
      cnt_q       <= 8'd0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= 32'h0000_0000;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      buf_valid_q <= buf_valid_d;
      buf_tag_q   <= buf_tag_d;
      buf_data_q  <= buf_data_d;
      stale_q     <= stale_d;
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      err_q       <= err_d;
    end
  end

  assign mem_req_o  = mem_req_q;
  assign mem_addr_o = mem_addr_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_mips_ifetch_bridge.sv
// Directed plus randomized bench for mips_ifetch_bridge against a transaction-level model.
module tb_mips_ifetch_bridge;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_i;
  logic        flush_i;
  logic [31:0] ins_o;
  logic        pause_o;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_rdata_i;
  logic        mem_ack_i;
  logic        err_o;

  int checks = 0;
  int passed = 0;

  // Model: the fetch buffer, plus one outstanding read (if any) with its age.
  logic        m_bv;
  logic [31:0] m_baddr;
  logic [31:0] m_bdata;
  logic        m_pend;
  logic [31:0] m_paddr;
  int          m_age;
  logic        m_poisoned;
  logic        m_err;
  logic [31:0] m_last_addr;

  mips_ifetch_bridge #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .pc_i(pc_i), .flush_i(flush_i), .ins_o(ins_o),
    .pause_o(pause_o), .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
    .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i), .err_o(err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_bv = 1'b0; m_baddr = 32'h0; m_bdata = 32'h0; m_pend = 1'b0;
    m_paddr = 32'h0; m_age = 0; m_poisoned = 1'b0; m_err = 1'b0; m_last_addr = 32'h0;
  endtask

  // One clock: drive inputs, compare against the model, advance both across the edge.
  task automatic step(input logic [31:0] pc, input logic fl, input logic ack,
                      input logic [31:0] rd, input logic r);
    logic        hit;
    logic [31:0] e_ins;
    logic        e_pause;
    logic        n_err;
    pc_i = pc; flush_i = fl; mem_ack_i = ack; mem_rdata_i = rd; rst = r;
    #3;
    hit = m_bv && (m_baddr[31:2] == pc[31:2]);
    e_ins = 32'h0; e_pause = 1'b1;
    if (!r && !m_pend && hit) begin
      e_ins = m_bdata; e_pause = 1'b0;
    end else if (!r && !m_pend && pc[1:0] != 2'b00) begin
      e_pause = 1'b0;
    end
    chk("ins", ins_o, e_ins);
    chk("pause", {31'd0, pause_o}, {31'd0, e_pause});
    chk("req", {31'd0, mem_req_o}, {31'd0, m_pend});
    chk("addr", mem_addr_o, m_last_addr);
    chk("err", {31'd0, err_o}, {31'd0, m_err});
    @(posedge clk);
    #1;
    if (r) begin
      model_reset();
    end else begin
      n_err = 1'b0;
      if (m_pend) begin
        if (ack) begin
          if (!m_poisoned && !fl) begin
            m_bv = 1'b1; m_baddr = m_paddr; m_bdata = rd;
          end
          m_pend = 1'b0;
        end else if (m_age + 1 == int'(TO)) begin
          m_pend = 1'b0; n_err = 1'b1;
        end else begin
          m_age++;
        end
        if (fl) begin
          m_bv = 1'b0; m_poisoned = 1'b1;
        end
      end else begin
        if (fl) m_bv = 1'b0;
        if (!hit) begin
          if (pc[1:0] == 2'b00) begin
            m_pend = 1'b1; m_paddr = {pc[31:2], 2'b00}; m_last_addr = m_paddr;
            m_age = 0; m_poisoned = 1'b0;
          end else begin
            n_err = 1'b1;
          end
        end
      end
      m_err = n_err;
    end
  endtask

  initial begin
    logic [31:0] pcs [6];
    pcs[0] = 32'h0000_0000; pcs[1] = 32'h0000_0004; pcs[2] = 32'h0000_0100;
    pcs[3] = 32'h0000_0104; pcs[4] = 32'h0000_0102; pcs[5] = 32'h0000_0008;

    rst = 1'b1; pc_i = 32'h0; flush_i = 1'b0; mem_ack_i = 1'b0; mem_rdata_i = 32'h0;
    @(posedge clk);
    #1;
    model_reset();
    step(32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
    step(32'h0, 1'b0, 1'b0, 32'h0, 1'b1);

    // Reset release, fetch 0x0 with one-cycle ack.
    step(32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    step(32'h0, 1'b0, 1'b1, 32'h0, 1'b0);
    chk("r30_pause", {31'd0, pause_o}, 32'd0);
    chk("r30_ins", ins_o, 32'h0);
    step(32'h0, 1'b0, 1'b0, 32'h0, 1'b0);

    // 0x100 with three wait cycles, then sequential 0x104.
    step(32'h100, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("r31_addr", mem_addr_o, 32'h100);
    step(32'h100, 1'b0, 1'b0, 32'h0, 1'b0);
    step(32'h100, 1'b0, 1'b0, 32'h0, 1'b0);
    step(32'h100, 1'b0, 1'b0, 32'h0, 1'b0);
    step(32'h100, 1'b0, 1'b1, 32'h0000_000C, 1'b0);
    chk("r31_pause", {31'd0, pause_o}, 32'd0);
    chk("r31_ins", ins_o, 32'h0000_000C);
    step(32'h100, 1'b0, 1'b0, 32'h0, 1'b0);
    step(32'h104, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("r31_req2", {31'd0, mem_req_o}, 32'd1);
    chk("r31_addr2", mem_addr_o, 32'h104);
    step(32'h104, 1'b0, 1'b1, 32'h2400_0001, 1'b0);

    // Timeout on 0x200.
    step(32'h200, 1'b0, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 4; i++) step(32'h200, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("r32_req_drop", {31'd0, mem_req_o}, 32'd0);
    chk("r32_err", {31'd0, err_o}, 32'd1);
    step(32'h200, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("r32_reissue", {31'd0, mem_req_o}, 32'd1);
    chk("r32_err_pulse", {31'd0, err_o}, 32'd0);
    step(32'h200, 1'b0, 1'b1, 32'hAAAA_5555, 1'b0);

    // Flush during WAIT discards the fill.
    step(32'h300, 1'b0, 1'b0, 32'h0, 1'b0);
    step(32'h300, 1'b1, 1'b0, 32'h0, 1'b0);
    step(32'h300, 1'b0, 1'b1, 32'h1234_5678, 1'b0);
    chk("r33_pause", {31'd0, pause_o}, 32'd1);
    chk("r33_ins", ins_o, 32'h0);
    step(32'h300, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("r33_rereq", {31'd0, mem_req_o}, 32'd1);

    // Ack together with flush: buffer stays empty.
    step(32'h300, 1'b1, 1'b1, 32'h1234_5678, 1'b0);
    chk("r35a_pause", {31'd0, pause_o}, 32'd1);
    step(32'h300, 1'b0, 1'b0, 32'h0, 1'b0);
    // Ack on the last allowed wait cycle: fill wins, no error.
    for (int i = 0; i < 3; i++) step(32'h300, 1'b0, 1'b0, 32'h0, 1'b0);
    step(32'h300, 1'b0, 1'b1, 32'hCAFE_F00D, 1'b0);
    chk("r35b_pause", {31'd0, pause_o}, 32'd0);
    chk("r35b_ins", ins_o, 32'hCAFE_F00D);
    chk("r35b_err", {31'd0, err_o}, 32'd0);

    // Misaligned fetch after the buffer is flushed.
    step(32'h302, 1'b1, 1'b0, 32'h0, 1'b0);
    step(32'h302, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("r34_err", {31'd0, err_o}, 32'd1);
    chk("r34_req", {31'd0, mem_req_o}, 32'd0);
    step(32'h400, 1'b0, 1'b0, 32'h0, 1'b0);

    // Reset in WAIT, then a late ack.
    step(32'h400, 1'b0, 1'b0, 32'h0, 1'b1);
    step(32'h400, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0);
    chk("r29_req", {31'd0, mem_req_o}, 32'd1);
    chk("r29_err", {31'd0, err_o}, 32'd0);
    step(32'h400, 1'b0, 1'b1, 32'h1111_2222, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      step(pcs[$urandom_range(5, 0)], ($urandom_range(9, 0) == 0),
           ($urandom_range(2, 0) == 0), $urandom, ($urandom_range(49, 0) == 0));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
